// File: rtl/uart_rx_os16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_os16
// Brief    : 16x-oversampled UART receiver (start/DBIT data/stop, LSB first).
//            Define UART_RX_PARITY_EN to add an even-parity bit before stop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os16 #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       parity_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  localparam logic [2:0] c_last_bit  = 3'(DBIT - 1);
  localparam logic [4:0] c_stop_last = 5'(SB_TICK - 1);

  logic       r_rx_meta, r_rx_s;
  state_t     r_state, w_state;
  logic [4:0] r_s, w_s;
  logic [2:0] r_n, w_n;
  logic [7:0] r_b, w_b, w_shift, w_dout;
  logic       w_done, w_ferr;
`ifdef UART_RX_PARITY_EN
  logic       r_par_bad, w_par_bad, w_perr;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_s          <= 5'd0;
      r_n          <= 3'd0;
      r_b          <= 8'h00;
      dout         <= 8'h00;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      r_state      <= w_state;
      r_s          <= w_s;
      r_n          <= w_n;
      r_b          <= w_b;
      dout         <= w_dout;
      rx_done_tick <= w_done;
      frame_err    <= w_ferr;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= w_par_bad;
      parity_err   <= w_perr;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // New bits enter at DBIT-1; bits above stay zero since r_b starts at zero.
  always_comb begin
    w_shift         = r_b >> 1;
    w_shift[DBIT-1] = r_rx_s;
  end

  always_comb begin
    w_state = r_state;
    w_s     = r_s;
    w_n     = r_n;
    w_b     = r_b;
    w_dout  = dout;
    w_done  = 1'b0;
    w_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad = r_par_bad;
    w_perr    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_s     = 5'd0;
          w_state = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (r_s == 5'd7) begin
            if (!r_rx_s) begin
              w_s     = 5'd0;
              w_n     = 3'd0;
              w_state = DATA;
            end else begin
              w_state = IDLE;
            end
          end else begin
            w_s = r_s + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s == 5'd15) begin
            w_b = w_shift;
            w_s = 5'd0;
            if (r_n == c_last_bit) begin
`ifdef UART_RX_PARITY_EN
              w_state = PARITY;
`else
              w_state = STOP;
`endif
            end else begin
              w_n = r_n + 3'd1;
            end
          end else begin
            w_s = r_s + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (r_s == 5'd15) begin
            w_par_bad = r_rx_s ^ (^r_b);
            w_s       = 5'd0;
            w_state   = STOP;
          end else begin
            w_s = r_s + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (r_s == c_stop_last) begin
            w_state = IDLE;
            w_ferr  = !r_rx_s;
`ifdef UART_RX_PARITY_EN
            w_perr  = r_par_bad;
            if (r_rx_s && !r_par_bad) begin
`else
            if (r_rx_s) begin
`endif
              w_dout = r_b;
              w_done = 1'b1;
            end
          end else begin
            w_s = r_s + 5'd1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_os16
// Brief    : Directed scoreboard bench for uart_rx_os16 (s_tick every 4 clk).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       s_tick;
  logic [7:0] dout;
  logic       rx_done_tick, frame_err, parity_err;

  int n_checks = 0;
  int n_fails  = 0;

  // kind = {parity_err, frame_err, rx_done_tick} expected on the pulse cycle
  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] last_good;

  uart_rx_os16 dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .s_tick      (s_tick),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset !== 1'b1 && (rx_done_tick || frame_err || parity_err)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {5'd0, parity_err, frame_err, rx_done_tick}, 8'h00);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulse_kind", {5'd0, parity_err, frame_err, rx_done_tick}, {5'd0, mon_e.kind});
        check("dout", dout, mon_e.data);
      end
    end
  end

  task automatic send_bit(input logic b, input int clks = 64);
    rx = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input int stop_clks = 64);
    logic par_bad;
    exp_t e;
`ifdef UART_RX_PARITY_EN
    par_bad = (par_b !== ^d);
`else
    par_bad = par_b & 1'b0;
`endif
    e.kind = {par_bad, !stop_b, stop_b && !par_bad};
    if (stop_b && !par_bad) last_good = d;
    e.data = last_good;
    sb_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`endif
    send_bit(stop_b, stop_clks);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
    check(tag, 8'(sb_q.size()), 8'h00);
  endtask

  initial begin : stim
    reset     = 1'b1;
    rx        = 1'b1;
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    check("reset_dout", dout, 8'h00);
    check("reset_done", {7'd0, rx_done_tick}, 8'h00);
    check("reset_ferr", {7'd0, frame_err}, 8'h00);
    check("reset_perr", {7'd0, parity_err}, 8'h00);

    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("idle_dout", dout, 8'h00);
    check("idle_pulses", {5'd0, parity_err, frame_err, rx_done_tick}, 8'h00);
    check("idle_queue", 8'(sb_q.size()), 8'h00);

    send_frame(8'hA5, 1'b1, 1'b0);
    send_bit(1'b1);
    drain("drain_a5");

    // back-to-back: second start bit directly follows first stop bit
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_bit(1'b1);
    drain("drain_b2b");
    check("b2b_dout", dout, 8'hFF);

    // low stop bit, released early enough that the re-armed start is rejected
    send_frame(8'h3C, 1'b0, 1'b0, 44);
    send_bit(1'b1, 128);
    drain("drain_ferr");
    check("ferr_dout_kept", dout, 8'hFF);

    // 5-tick glitch is a false start
    send_bit(1'b0, 20);
    send_bit(1'b1, 128);
    check("glitch_queue", 8'(sb_q.size()), 8'h00);
    check("glitch_dout", dout, 8'hFF);
    send_frame(8'h5A, 1'b1, 1'b0);
    send_bit(1'b1);
    drain("drain_5a");

    // reset during data bit 4 of 0x81
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0, 30);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_dout", dout, 8'h00);
    check("midreset_pulses", {5'd0, parity_err, frame_err, rx_done_tick}, 8'h00);
    rx        = 1'b1;
    last_good = 8'h00;
    reset     = 1'b0;
    repeat (100) @(negedge clk);
    check("postreset_queue", 8'(sb_q.size()), 8'h00);
    send_frame(8'h42, 1'b1, 1'b0);
    send_bit(1'b1);
    drain("drain_42");
    check("final_dout", dout, 8'h42);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1);
    drain("drain_par_ok");
    send_frame(8'h07, 1'b1, 1'b0);
    send_bit(1'b1);
    drain("drain_par_bad");
    check("par_dout_kept", dout, 8'h07);
`endif

    repeat (50) @(negedge clk);
    check("end_queue", 8'(sb_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
